uart_rx: RTL and testbench

//  Serial receive side of the UART. Consumes the 32x-oversampling enable (ce_32)

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared receiver constants and FSM encoding for the UART.
// Oversampling is fixed at 32 ticks per bit, with the bit centre at tick 16.
package uart_rx_pkg;

   localparam int unsigned TicksPerBit = 32;
   localparam int unsigned HalfBit     = 16;

   // Tick counter values on which samples are taken (counter starts at 0).
   localparam logic [4:0] TickLast = 5'(TicksPerBit - 1);
   localparam logic [4:0] TickHalf = 5'(HalfBit - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input, with a configurable reset value.
module uart_sync2 #(
   parameter logic ResetVal = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 32x oversampled, centre-sampled, LSB-first, with framing error detection.
// Define UART_RX_PARITY_EN to expect and check one parity bit after the data bits.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ce_32,
   input  logic                 ser_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 new_rx_data,
   output logic                 framing_err,
   output logic                 parity_err
);

`ifdef UART_RX_PARITY_EN
   localparam bit ParityEn = 1'b1;
`else
   localparam bit ParityEn = 1'b0;
`endif

   localparam logic [2:0] BitLast = 3'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_e            state_q, state_d;
   logic [4:0]           tick_q, tick_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 new_q, new_d;
   logic                 fe_q, fe_d;
   logic                 pe_q, pe_d;

   uart_sync2 #(
      .ResetVal (1'b1)
   ) u_sync (
      .clock (clock),
      .reset (reset),
      .d_i   (ser_in),
      .q_o   (rx_s)
   );

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      rx_data_d = rx_data_q;
      new_d     = 1'b0;
      fe_d      = 1'b0;
      pe_d      = 1'b0;

      if (ce_32) begin
         tick_d = tick_q + 5'd1;
         unique case (state_q)
            StIdle: begin
               tick_d = '0;
               if (!rx_s) begin
                  state_d = StStart;
               end
            end
            StStart: begin
               if (tick_q == TickHalf) begin
                  // Realign so later samples land 32 ticks apart at each bit centre.
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = rx_s ? StIdle : StData;
               end
            end
            StData: begin
               if (tick_q == TickLast) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == BitLast) begin
                     state_d = ParityEn ? StParity : StStop;
                  end
               end
            end
            StParity: begin
               if (tick_q == TickLast) begin
                  par_d   = rx_s;
                  state_d = StStop;
               end
            end
            StStop: begin
               if (tick_q == TickLast) begin
                  if (rx_s) begin
                     rx_data_d = shift_q;
                     new_d     = 1'b1;
                     pe_d      = ParityEn && ((^{shift_q, par_q}) != (PARITY_ODD != 0));
                     state_d   = StIdle;
                  end else begin
                     fe_d    = 1'b1;
                     state_d = StBreak;
                  end
               end
            end
            StBreak: begin
               tick_d = '0;
               if (rx_s) begin
                  state_d = StIdle;
               end
            end
            default: begin
               tick_d  = '0;
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         rx_data_q <= '0;
         new_q     <= 1'b0;
         fe_q      <= 1'b0;
         pe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         rx_data_q <= rx_data_d;
         new_q     <= new_d;
         fe_q      <= fe_d;
         pe_q      <= pe_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign new_rx_data = new_q;
   assign framing_err = fe_q;
   assign parity_err  = pe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 50 MHz clock, fractional baud generator for 115200 baud x32.
`timescale 1ns/1ps
module tb_uart_rx;

   logic       clock  = 1'b0;
   logic       reset  = 1'b1;
   logic       ce_32  = 1'b0;
   logic       ser_in = 1'b1;
   logic [7:0] rx_data;
   logic       new_rx_data;
   logic       framing_err;
   logic       parity_err;

   int unsigned n_asserts = 0;
   int unsigned n_fail    = 0;
   int unsigned n_strobe  = 0;
   int unsigned n_ferr    = 0;
   int unsigned acc       = 0;
   logic [8:0]  exp_q[$];  // {parity_err, data}

   uart_rx #(
      .DATA_BITS  (8),
      .PARITY_ODD (0)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ce_32       (ce_32),
      .ser_in      (ser_in),
      .rx_data     (rx_data),
      .new_rx_data (new_rx_data),
      .framing_err (framing_err),
      .parity_err  (parity_err)
   );

   always #10 clock = ~clock;

   // ce_32 rate = 115200 * 32 / 50e6, via a phase accumulator updated off the active edge.
   always @(negedge clock) begin
      if (acc + 32'd3686400 >= 32'd50000000) begin
         acc   = acc + 32'd3686400 - 32'd50000000;
         ce_32 = 1'b1;
      end else begin
         acc   = acc + 32'd3686400;
         ce_32 = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin : monitor
      logic [8:0] e;
      if (!reset) begin
         if (framing_err) n_ferr++;
         if (new_rx_data) begin
            n_strobe++;
            n_asserts++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_strobe: observed rx_data 0x%0h expected no strobe", rx_data);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(e[7:0]));
               check("parity_err", 32'(parity_err), 32'(e[8]));
               check("ferr_with_data", 32'(framing_err), 32'd0);
            end
         end
      end
   end

   task automatic wait_ce(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         while (!ce_32) @(posedge clock);
      end
      #1;
   endtask

   task automatic drive_bit(input logic b);
      ser_in = b;
      wait_ce(32);
   endtask

   task automatic send_bits(input logic [7:0] d);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
   endtask

   // Well-formed frame; with parity enabled the parity bit is the even-parity value.
   task automatic send_good(input logic [7:0] d);
      exp_q.push_back({1'b0, d});
      send_bits(d);
`ifdef UART_RX_PARITY_EN
      drive_bit(^d);
`endif
      drive_bit(1'b1);
   endtask

   initial begin : stim
      int unsigned s0;
      int unsigned f0;
      logic [7:0]  v;

      repeat (5) @(posedge clock);
      #1;
      check("rst_rx_data", 32'(rx_data), 32'h0);
      check("rst_new", 32'(new_rx_data), 32'h0);
      check("rst_ferr", 32'(framing_err), 32'h0);
      check("rst_perr", 32'(parity_err), 32'h0);
      reset = 1'b0;
      wait_ce(64);

      // 1: single frame
      s0 = n_strobe;
      send_good(8'hA5);
      check("t1_strobes", n_strobe - s0, 32'd1);
      check("t1_ferr", n_ferr, 32'd0);

      // 2: back-to-back frames
      s0 = n_strobe;
      send_good(8'h00);
      send_good(8'hFF);
      check("t2_strobes", n_strobe - s0, 32'd2);
      check("t2_hold", 32'(rx_data), 32'hFF);

      // 3: short low glitch is rejected as a false start
      s0 = n_strobe;
      f0 = n_ferr;
      ser_in = 1'b0;
      wait_ce(10);
      ser_in = 1'b1;
      wait_ce(64);
      check("t3_no_strobe", n_strobe - s0, 32'd0);
      check("t3_no_ferr", n_ferr - f0, 32'd0);
      send_good(8'h3C);
      check("t3_strobes", n_strobe - s0, 32'd1);

      // 4: stop bit low, line held low for 3 more bit times
      s0 = n_strobe;
      f0 = n_ferr;
      send_bits(8'h55);
`ifdef UART_RX_PARITY_EN
      drive_bit(1'b0);
`endif
      ser_in = 1'b0;
      wait_ce(32 * 4);
      ser_in = 1'b1;
      wait_ce(32);
      check("t4_ferr_pulses", n_ferr - f0, 32'd1);
      check("t4_no_strobe", n_strobe - s0, 32'd0);
      check("t4_rx_hold", 32'(rx_data), 32'h3C);
      send_good(8'h81);
      check("t4_recover", n_strobe - s0, 32'd1);

      // 5: reset mid data bit 4 of 0xC3
      s0 = n_strobe;
      v = 8'hC3;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(v[i]);
      ser_in = v[4];
      wait_ce(16);
      #3 reset = 1'b1;
      #2;
      check("t5_async_rx_data", 32'(rx_data), 32'h0);
      check("t5_async_new", 32'(new_rx_data), 32'h0);
      ser_in = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      check("t5_rx_data", 32'(rx_data), 32'h0);
      check("t5_ferr", 32'(framing_err), 32'h0);
      check("t5_perr", 32'(parity_err), 32'h0);
      wait_ce(64);
      check("t5_no_strobe", n_strobe - s0, 32'd0);
      send_good(8'h12);
      check("t5_strobes", n_strobe - s0, 32'd1);

`ifdef UART_RX_PARITY_EN
      // 6: 0x07 has odd weight; even parity wants parity bit 1
      s0 = n_strobe;
      exp_q.push_back({1'b0, 8'h07});
      send_bits(8'h07);
      drive_bit(1'b1);
      drive_bit(1'b1);
      exp_q.push_back({1'b1, 8'h07});
      send_bits(8'h07);
      drive_bit(1'b0);
      drive_bit(1'b1);
      check("t6_strobes", n_strobe - s0, 32'd2);
`endif

      wait_ce(32);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
